id_ex_stage: RTL and testbench

- ID/EX pipeline stage directly downstream of RegisterFile.
- Captures ReadData1/ReadData2 plus the decoded control and immediate fields, and presents them registered to the EX stage.
- Provides a WB-to-ID write-through bypass, because RegisterFile writes on the clock edge and a same-cycle read returns stale data.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and flush.

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass,
// load-use hazard detection, bubble insertion and bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   input  logic              Stall,
   input  logic              Flush,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] WriteRegisterIn,
   input  logic [15:0]       Imm,
   input  logic              SignExtend,
   input  logic [3:0]        ALUOpIn,
   input  logic              RegWriteIn,
   input  logic              MemReadIn,
   input  logic              MemWriteIn,
   input  logic              MemToRegIn,
   input  logic              WBRegWrite,
   input  logic [ADDR_W-1:0] WBWriteRegister,
   input  logic [DATA_W-1:0] WBWriteData,
   output logic              ValidOut,
   output logic [DATA_W-1:0] RsData,
   output logic [DATA_W-1:0] RtData,
   output logic [DATA_W-1:0] ImmOut,
   output logic [ADDR_W-1:0] RsOut,
   output logic [ADDR_W-1:0] RtOut,
   output logic [ADDR_W-1:0] WriteRegisterOut,
   output logic [3:0]        ALUOpOut,
   output logic              RegWriteOut,
   output logic              MemReadOut,
   output logic              MemWriteOut,
   output logic              MemToRegOut,
   output logic              LoadUseHazard,
   output logic [CNT_W-1:0]  BubbleCount
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [ADDR_W-1:0] rs_q, rs_d;
   logic [ADDR_W-1:0] rt_q, rt_d;
   logic [ADDR_W-1:0] wr_q, wr_d;
   logic [3:0]        alu_q, alu_d;
   logic              rw_q, rw_d;
   logic              mr_q, mr_d;
   logic              mw_q, mw_d;
   logic              m2r_q, m2r_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [DATA_W-1:0] op1, op2, imm_ext;
   logic              hazard;

   // Operand select: $0 reads zero, else WB write-through, else regfile
   always_comb begin
      op1 = ReadData1;
      op2 = ReadData2;
      if (ReadRegister1 == '0)
         op1 = '0;
      else if (WBRegWrite && WBWriteRegister == ReadRegister1)
         op1 = WBWriteData;
      if (ReadRegister2 == '0)
         op2 = '0;
      else if (WBRegWrite && WBWriteRegister == ReadRegister2)
         op2 = WBWriteData;
      imm_ext = SignExtend ? {{(DATA_W-16){Imm[15]}}, Imm}
                           : {{(DATA_W-16){1'b0}}, Imm};
   end

   // Load in EX whose destination is read by the instruction in ID
   assign hazard = !Reset && InValid && valid_q && mr_q &&
                   wr_q != '0 &&
                   (wr_q == ReadRegister1 || wr_q == ReadRegister2);

   // Next-state selection: flush, then bubble, then normal capture
   always_comb begin
      valid_d   = valid_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      wr_d      = wr_q;
      alu_d     = alu_q;
      rw_d      = rw_q;
      mr_d      = mr_q;
      mw_d      = mw_q;
      m2r_d     = m2r_q;
      cnt_d     = cnt_q;
      if (Flush || !hazard) begin
         rs_data_d = op1;
         rt_data_d = op2;
         imm_d     = imm_ext;
         rs_d      = ReadRegister1;
         rt_d      = ReadRegister2;
         wr_d      = WriteRegisterIn;
         alu_d     = ALUOpIn;
      end
      if (Flush || hazard) begin
         valid_d = 1'b0;
         rw_d    = 1'b0;
         mr_d    = 1'b0;
         mw_d    = 1'b0;
         m2r_d   = 1'b0;
      end else begin
         valid_d = InValid;
         rw_d    = InValid & RegWriteIn;
         mr_d    = InValid & MemReadIn;
         mw_d    = InValid & MemWriteIn;
         m2r_d   = InValid & MemToRegIn;
      end
      if (!Flush && hazard && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Pipeline register; stall freezes everything
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q   <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wr_q      <= '0;
         alu_q     <= '0;
         rw_q      <= 1'b0;
         mr_q      <= 1'b0;
         mw_q      <= 1'b0;
         m2r_q     <= 1'b0;
         cnt_q     <= '0;
      end else if (!Stall) begin
         valid_q   <= valid_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         wr_q      <= wr_d;
         alu_q     <= alu_d;
         rw_q      <= rw_d;
         mr_q      <= mr_d;
         mw_q      <= mw_d;
         m2r_q     <= m2r_d;
         cnt_q     <= cnt_d;
      end
   end

   assign ValidOut         = valid_q;
   assign RsData           = rs_data_q;
   assign RtData           = rt_data_q;
   assign ImmOut           = imm_q;
   assign RsOut            = rs_q;
   assign RtOut            = rt_q;
   assign WriteRegisterOut = wr_q;
   assign ALUOpOut         = alu_q;
   assign RegWriteOut      = rw_q;
   assign MemReadOut       = mr_q;
   assign MemWriteOut      = mw_q;
   assign MemToRegOut      = m2r_q;
   assign LoadUseHazard    = hazard;
   assign BubbleCount      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus
// hand sequences for reset, load-use, stall/flush, saturation.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 2;

   logic          clk = 1'b1;
   logic          rst;
   logic          inv, stall, flush;
   logic [AW-1:0] rr1, rr2, wri, wbreg;
   logic [DW-1:0] rd1, rd2, wbdata;
   logic [15:0]   imm;
   logic          sext, wbwe;
   logic [3:0]    alui;
   logic          rwi, mri, mwi, m2ri;
   logic          vo, rwo, mro, mwo, m2ro, haz;
   logic [DW-1:0] rso_d, rto_d, immo;
   logic [AW-1:0] rso, rto, wro;
   logic [3:0]    aluo;
   logic [CW-1:0] bcnt;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .Clk(clk), .Reset(rst), .InValid(inv), .Stall(stall),
      .Flush(flush), .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1), .ReadData2(rd2), .WriteRegisterIn(wri),
      .Imm(imm), .SignExtend(sext), .ALUOpIn(alui),
      .RegWriteIn(rwi), .MemReadIn(mri), .MemWriteIn(mwi),
      .MemToRegIn(m2ri), .WBRegWrite(wbwe),
      .WBWriteRegister(wbreg), .WBWriteData(wbdata),
      .ValidOut(vo), .RsData(rso_d), .RtData(rto_d),
      .ImmOut(immo), .RsOut(rso), .RtOut(rto),
      .WriteRegisterOut(wro), .ALUOpOut(aluo),
      .RegWriteOut(rwo), .MemReadOut(mro), .MemWriteOut(mwo),
      .MemToRegOut(m2ro), .LoadUseHazard(haz), .BubbleCount(bcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      inv = 0; stall = 0; flush = 0;
      rr1 = 0; rr2 = 0; rd1 = 0; rd2 = 0; wri = 0;
      imm = 0; sext = 0; alui = 0;
      rwi = 0; mri = 0; mwi = 0; m2ri = 0;
      wbwe = 0; wbreg = 0; wbdata = 0;
   endtask

   typedef struct {
      logic [4:0]  r1, r2;
      logic [31:0] d1, d2;
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdat;
      logic [15:0] im;
      logic        se, v;
      logic [3:0]  alu;
      logic        rw, mw;
      logic [4:0]  wr;
      logic [31:0] e_rs, e_rt, e_imm;
      logic        e_v, e_rw, e_mw;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{5'd10, 5'd11, 32'd0, 32'd5, 1'b1, 5'd10, 32'd20,
                 16'hFFFE, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 5'd12,
                 32'd20, 32'd5, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{5'd10, 5'd11, 32'd0, 32'd5, 1'b0, 5'd10, 32'd20,
                 16'hFFFE, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 5'd13,
                 32'd0, 32'd5, 32'h0000FFFE, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{5'd4, 5'd0, 32'd33, 32'd77, 1'b1, 5'd0, 32'd99,
                 16'h0010, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 5'd0,
                 32'd33, 32'd0, 32'h00000010, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{5'd7, 5'd7, 32'd1, 32'd2, 1'b1, 5'd7, 32'hABCD,
                 16'h8000, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 5'd7,
                 32'hABCD, 32'hABCD, 32'h00008000, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{5'd6, 5'd9, 32'h11, 32'h22, 1'b1, 5'd8, 32'h55,
                 16'h8000, 1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 5'd3,
                 32'h11, 32'h22, 32'hFFFF8000, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{5'd0, 5'd2, 32'h99, 32'h44, 1'b0, 5'd0, 32'h0,
                 16'h7FFF, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 5'd14,
                 32'h0, 32'h44, 32'h00007FFF, 1'b1, 1'b1, 1'b1};

      idle();
      rst = 1;
      #2;
      chk("reset_valid", {31'b0, vo}, 0);
      chk("reset_haz", {31'b0, haz}, 0);
      #5;
      // t=7: release reset, present lw $8
      rst = 0;
      inv = 1; mri = 1; rwi = 1; m2ri = 1; wri = 8;
      rr1 = 2; rd1 = 100;
      @(posedge clk); #1;
      chk("lw_valid", {31'b0, vo}, 1);
      chk("lw_memread", {31'b0, mro}, 1);
      chk("lw_wr", {27'b0, wro}, 8);
      #1;
      // dependent instruction using $8
      mri = 0; m2ri = 0; wri = 9; rr1 = 8; rd1 = 32'h1234;
      #1;
      chk("lu_haz", {31'b0, haz}, 1);
      @(posedge clk); #1;
      chk("lu_bubble_valid", {31'b0, vo}, 0);
      chk("lu_bubble_rw", {31'b0, rwo}, 0);
      chk("lu_count", {30'b0, bcnt}, 1);
      chk("lu_haz_drop", {31'b0, haz}, 0);
      @(posedge clk); #1;
      chk("lu_reload_valid", {31'b0, vo}, 1);
      chk("lu_reload_rs", rso_d, 32'h1234);
      chk("lu_reload_wr", {27'b0, wro}, 9);
      #4;
      // t=35: asynchronous reset between edges
      rst = 1;
      #1;
      chk("areset_valid", {31'b0, vo}, 0);
      chk("areset_rs", rso_d, 0);
      chk("areset_wr", {27'b0, wro}, 0);
      chk("areset_rw", {31'b0, rwo}, 0);
      chk("areset_cnt", {30'b0, bcnt}, 0);
      chk("areset_haz", {31'b0, haz}, 0);
      idle();
      #2;
      rst = 0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rr1 = tbl[i].r1; rr2 = tbl[i].r2;
         rd1 = tbl[i].d1; rd2 = tbl[i].d2;
         wbwe = tbl[i].we; wbreg = tbl[i].wreg;
         wbdata = tbl[i].wdat;
         imm = tbl[i].im; sext = tbl[i].se; inv = tbl[i].v;
         alui = tbl[i].alu; rwi = tbl[i].rw; mwi = tbl[i].mw;
         wri = tbl[i].wr; mri = 0; m2ri = 0;
         @(posedge clk); #1;
         chk($sformatf("v%0d_rs", i), rso_d, tbl[i].e_rs);
         chk($sformatf("v%0d_rt", i), rto_d, tbl[i].e_rt);
         chk($sformatf("v%0d_imm", i), immo, tbl[i].e_imm);
         chk($sformatf("v%0d_valid", i), {31'b0, vo},
             {31'b0, tbl[i].e_v});
         chk($sformatf("v%0d_rw", i), {31'b0, rwo},
             {31'b0, tbl[i].e_rw});
         chk($sformatf("v%0d_mw", i), {31'b0, mwo},
             {31'b0, tbl[i].e_mw});
         chk($sformatf("v%0d_alu", i), {28'b0, aluo},
             {28'b0, tbl[i].alu});
         chk($sformatf("v%0d_wr", i), {27'b0, wro},
             {27'b0, tbl[i].wr});
         chk($sformatf("v%0d_rsaddr", i), {27'b0, rso},
             {27'b0, tbl[i].r1});
      end
      chk("table_cnt", {30'b0, bcnt}, 0);

      // stall with flush: hold the last vector's state
      @(negedge clk);
      stall = 1; flush = 1;
      rr1 = 3; rd1 = 55; imm = 16'h1; inv = 1; rwi = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("stall_valid", {31'b0, vo}, 1);
      chk("stall_rw", {31'b0, rwo}, 1);
      chk("stall_mw", {31'b0, mwo}, 1);
      chk("stall_rs", rso_d, 0);
      chk("stall_imm", immo, 32'h00007FFF);
      @(negedge clk);
      stall = 0;
      @(posedge clk); #1;
      chk("flush_valid", {31'b0, vo}, 0);
      chk("flush_rw", {31'b0, rwo}, 0);
      chk("flush_mw", {31'b0, mwo}, 0);
      chk("flush_cnt", {30'b0, bcnt}, 0);

      // saturation: self-dependent lw $8,0($8) held in ID
      @(negedge clk);
      rst = 1;
      idle();
      #1;
      rst = 0;
      inv = 1; mri = 1; rwi = 1; m2ri = 1; wri = 8; rr1 = 8;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("sat%0d_load", i), {31'b0, vo}, 1);
         chk($sformatf("sat%0d_haz", i), {31'b0, haz}, 1);
         @(posedge clk); #1;
         chk($sformatf("sat%0d_bubble", i), {31'b0, vo}, 0);
         chk($sformatf("sat%0d_cnt", i), {30'b0, bcnt},
             (i < 3) ? i + 1 : 3);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
